// File: rtl/multi_vu_meter.sv
// -----------------------------------------------------------------------------
// multi_vu_meter
//
// Multi-channel VU meter core. A tagged, offset-binary sample stream from the
// ADC front end is full-wave rectified and reduced per channel to a windowed
// peak level. Each channel also keeps a peak-hold marker that is held for a
// number of windows and then decays. One operator-selected channel is
// quantised onto an LEDS-wide bar graph, optionally with a peak dot.
//
// Ports
//   clk          : single clock, all logic in this domain
//   rst          : asynchronous active-high reset
//   sample_valid : accept sample_ch/sample_data on this edge
//   sample_ch    : channel tag; tags >= CHANNELS are ignored
//   sample_data  : raw offset-binary ADC code
//   disp_sel     : channel shown on leds; >= CHANNELS blanks the display
//   mode         : 0 = bar, 1 = bar plus peak dot
//   leds         : registered bar pattern, bit 0 is the lowest LED
//   frame_done   : one-cycle pulse after any channel completes a window
//   frame_ch     : channel that completed; valid while frame_done is high
// -----------------------------------------------------------------------------
module multi_vu_meter #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 12,
    parameter int LEDS     = 8,
    parameter int WINDOW   = 512,
    parameter int HOLD     = 16,
    parameter int DECAY_SH = 3,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [CH_W-1:0]   sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [CH_W-1:0]   disp_sel,
    input  logic              mode,
    output logic [LEDS-1:0]   leds,
    output logic              frame_done,
    output logic [CH_W-1:0]   frame_ch
);

    localparam int MAG_W  = DATA_W - 1;
    localparam int WC_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int HC_W   = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    // LEDS <= 16, so a count of 0..LEDS always fits in five bits.
    localparam int CNT_W  = 5;
    localparam int PROD_W = MAG_W + CNT_W;

    localparam logic [MAG_W-1:0] MAG_ZERO  = {MAG_W{1'b0}};
    localparam logic [MAG_W-1:0] MAG_ONE   = MAG_W'(1'b1);
    localparam logic [WC_W-1:0]  WC_ZERO   = {WC_W{1'b0}};
    localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1'b1);
    localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(WINDOW - 1);
    localparam logic [HC_W-1:0]  HC_ZERO   = {HC_W{1'b0}};
    localparam logic [HC_W-1:0]  HC_ONE    = HC_W'(1'b1);
    localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(HOLD);
    localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);
    localparam logic [CH_W-1:0]  CH_ZERO   = {CH_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    // Full-wave rectify around the midpoint. Above the midpoint the low bits
    // already equal d - mid; below it, mid - 1 - d is the bitwise inverse of
    // the low bits, so no subtractor is needed.
    function automatic logic [MAG_W-1:0] rectify(input logic [DATA_W-1:0] d);
        if (d[DATA_W-1]) begin
            rectify = d[MAG_W-1:0];
        end else begin
            rectify = ~d[MAG_W-1:0];
        end
    endfunction

    // Number of lit LEDs for a magnitude: (x * (LEDS+1)) >> MAG_W.
    function automatic logic [CNT_W-1:0] quantise(input logic [MAG_W-1:0] x);
        quantise = CNT_W'((PROD_W'(x) * PROD_W'(LEDS + 1)) >> MAG_W);
    endfunction

    // Decayed peak: drop by max(1, peak >> DECAY_SH), floor at zero, but never
    // below the level of the window just completed.
    function automatic logic [MAG_W-1:0] decay_target(input logic [MAG_W-1:0] peak,
                                                      input logic [MAG_W-1:0] win_max);
        logic [MAG_W-1:0] step;
        logic [MAG_W-1:0] dropped;
        step = peak >> DECAY_SH;
        if (step == MAG_ZERO) begin
            step = MAG_ONE;
        end else begin
            step = step;
        end
        if (peak > step) begin
            dropped = peak - step;
        end else begin
            dropped = MAG_ZERO;
        end
        if (win_max > dropped) begin
            decay_target = win_max;
        end else begin
            decay_target = dropped;
        end
    endfunction

    // Per-channel state
    logic [MAG_W-1:0] run_max_r  [CHANNELS];
    logic [MAG_W-1:0] level_r    [CHANNELS];
    logic [MAG_W-1:0] peak_r     [CHANNELS];
    logic [WC_W-1:0]  win_cnt_r  [CHANNELS];
    logic [HC_W-1:0]  hold_cnt_r [CHANNELS];

    logic              frame_done_r;
    logic [CH_W-1:0]   frame_ch_r;
    logic [LEDS-1:0]   leds_r;

    // Sample path
    logic              sample_ok_s;
    logic [CH_W-1:0]   idx_s;
    logic [MAG_W-1:0]  mag_s;
    logic [MAG_W-1:0]  new_max_s;
    logic              win_end_s;
    logic [MAG_W-1:0]  peak_nxt_s;
    logic [HC_W-1:0]   hold_nxt_s;

    // Display path
    logic              disp_ok_s;
    logic [CH_W-1:0]   didx_s;
    logic [CNT_W-1:0]  lvl_cnt_s;
    logic [CNT_W-1:0]  pk_cnt_s;
    logic [LEDS-1:0]   bar_s;
    logic [LEDS-1:0]   dot_s;
    logic [LEDS-1:0]   leds_nxt_s;

    // Rectify the incoming sample and work out the channel's next window/peak state.
    always_comb begin
        sample_ok_s = sample_valid && ({1'b0, sample_ch} < CH_LIMIT);
        // Invalid tags are parked on channel 0 only so the array read stays in range;
        // sample_ok_s gates every write.
        if (sample_ok_s) begin
            idx_s = sample_ch;
        end else begin
            idx_s = CH_ZERO;
        end
        mag_s = rectify(sample_data);
        if (mag_s > run_max_r[idx_s]) begin
            new_max_s = mag_s;
        end else begin
            new_max_s = run_max_r[idx_s];
        end
        win_end_s  = (win_cnt_r[idx_s] == WIN_LAST);
        peak_nxt_s = peak_r[idx_s];
        hold_nxt_s = hold_cnt_r[idx_s];
        if (new_max_s >= peak_r[idx_s]) begin
            peak_nxt_s = new_max_s;
            hold_nxt_s = HOLD_INIT;
        end else if (hold_cnt_r[idx_s] != HC_ZERO) begin
            hold_nxt_s = hold_cnt_r[idx_s] - HC_ONE;
        end else begin
            peak_nxt_s = decay_target(peak_r[idx_s], new_max_s);
        end
    end

    // Per-channel window accumulation, level capture and peak tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                run_max_r[c]  <= MAG_ZERO;
                level_r[c]    <= MAG_ZERO;
                peak_r[c]     <= MAG_ZERO;
                win_cnt_r[c]  <= WC_ZERO;
                hold_cnt_r[c] <= HC_ZERO;
            end
        end else if (sample_ok_s) begin
            if (win_end_s) begin
                level_r[idx_s]    <= new_max_s;
                run_max_r[idx_s]  <= MAG_ZERO;
                win_cnt_r[idx_s]  <= WC_ZERO;
                peak_r[idx_s]     <= peak_nxt_s;
                hold_cnt_r[idx_s] <= hold_nxt_s;
            end else begin
                run_max_r[idx_s]  <= new_max_s;
                win_cnt_r[idx_s]  <= win_cnt_r[idx_s] + WC_ONE;
            end
        end
    end

    // Window-complete pulse and the channel that produced it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_r <= 1'b0;
            frame_ch_r   <= CH_ZERO;
        end else begin
            frame_done_r <= sample_ok_s && win_end_s;
            if (sample_ok_s && win_end_s) begin
                frame_ch_r <= sample_ch;
            end
        end
    end

    // Quantise the selected channel into a bar, plus a dot at the peak position.
    always_comb begin
        disp_ok_s = ({1'b0, disp_sel} < CH_LIMIT);
        if (disp_ok_s) begin
            didx_s = disp_sel;
        end else begin
            didx_s = CH_ZERO;
        end
        lvl_cnt_s = quantise(level_r[didx_s]);
        pk_cnt_s  = quantise(peak_r[didx_s]);
        bar_s     = {LEDS{1'b0}};
        dot_s     = {LEDS{1'b0}};
        for (int i = 0; i < LEDS; i++) begin
            bar_s[i] = (CNT_W'(i) < lvl_cnt_s);
            // Dot sits on LED count-1; a count of zero never matches i+1.
            dot_s[i] = mode && (pk_cnt_s != CNT_ZERO) && (pk_cnt_s == CNT_W'(i + 1));
        end
        if (disp_ok_s) begin
            leds_nxt_s = bar_s | dot_s;
        end else begin
            leds_nxt_s = {LEDS{1'b0}};
        end
    end

    // Display register so leds is a clean flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_r <= {LEDS{1'b0}};
        end else begin
            leds_r <= leds_nxt_s;
        end
    end

    assign leds       = leds_r;
    assign frame_done = frame_done_r;
    assign frame_ch   = frame_ch_r;

endmodule

// File: tb/tb_multi_vu_meter.sv
module tb_multi_vu_meter;

    localparam int CH  = 2;
    localparam int DW  = 12;
    localparam int NL  = 8;
    localparam int WIN = 4;
    localparam int HLD = 2;
    localparam int DSH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        sample_valid = 1'b0;
    logic [0:0]  sample_ch    = 1'b0;
    logic [11:0] sample_data  = 12'd0;
    logic [0:0]  disp_sel     = 1'b0;
    logic        mode         = 1'b0;
    logic [7:0]  leds;
    logic        frame_done;
    logic [0:0]  frame_ch;

    logic        v3    = 1'b0;
    logic [1:0]  ch3   = 2'd0;
    logic [11:0] data3 = 12'd0;
    logic [1:0]  disp3 = 2'd0;
    logic        mode3 = 1'b0;
    logic [7:0]  leds3;
    logic        fd3;
    logic [1:0]  fch3;

    int checks   = 0;
    int failures = 0;

    multi_vu_meter #(.CHANNELS(CH), .DATA_W(DW), .LEDS(NL), .WINDOW(WIN),
                     .HOLD(HLD), .DECAY_SH(DSH)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .disp_sel(disp_sel), .mode(mode),
        .leds(leds), .frame_done(frame_done), .frame_ch(frame_ch));

    multi_vu_meter #(.CHANNELS(3), .DATA_W(DW), .LEDS(NL), .WINDOW(WIN),
                     .HOLD(HLD), .DECAY_SH(DSH)) dut3 (
        .clk(clk), .rst(rst), .sample_valid(v3), .sample_ch(ch3),
        .sample_data(data3), .disp_sel(disp3), .mode(mode3),
        .leds(leds3), .frame_done(fd3), .frame_ch(fch3));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int ch; int mag; } pend_t;
    pend_t pend[$];
    int m_level[CH];
    int m_peak[CH];
    int m_hold[CH];

    function automatic int mag_of(input int d);
        return (d >= 2048) ? d - 2048 : 2047 - d;
    endfunction

    function automatic int cnt_of(input int x);
        return (x * (NL + 1)) / 2048;
    endfunction

    function automatic logic [7:0] model_leds(input int s, input int m);
        int lc, pc, pat;
        if (s >= CH) return 8'h00;
        lc  = cnt_of(m_level[s]);
        pc  = cnt_of(m_peak[s]);
        pat = (1 << lc) - 1;
        if (m != 0 && pc > 0) pat = pat | (1 << (pc - 1));
        return pat[7:0];
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int c = 0; c < CH; c++) begin
            m_level[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
        end
    endtask

    task automatic model_sample(input int c, input int d, output bit fd);
        int n, mx, step, np;
        pend_t keep[$];
        pend_t e;
        e.ch = c; e.mag = mag_of(d);
        pend.push_back(e);
        n = 0; mx = 0;
        foreach (pend[i]) if (pend[i].ch == c) begin
            n++;
            if (pend[i].mag > mx) mx = pend[i].mag;
        end
        fd = 1'b0;
        if (n == WIN) begin
            fd = 1'b1;
            m_level[c] = mx;
            foreach (pend[i]) if (pend[i].ch != c) keep.push_back(pend[i]);
            pend = keep;
            if (mx >= m_peak[c]) begin
                m_peak[c] = mx; m_hold[c] = HLD;
            end else if (m_hold[c] != 0) begin
                m_hold[c] = m_hold[c] - 1;
            end else begin
                step = m_peak[c] >> DSH;
                if (step < 1) step = 1;
                np = m_peak[c] - step;
                if (np < 0) np = 0;
                m_peak[c] = (mx > np) ? mx : np;
            end
        end
    endtask

    // One clock on the main DUT, checked against the model.
    task automatic cycle(input bit v, input int c, input int d, input int ds, input int md);
        logic [7:0] exp_l;
        bit exp_fd;
        sample_valid = v; sample_ch = c[0:0]; sample_data = d[11:0];
        disp_sel = ds[0:0]; mode = md[0];
        exp_l  = model_leds(ds, md);
        exp_fd = 1'b0;
        if (v && c < CH) model_sample(c, d, exp_fd);
        @(posedge clk); #1;
        check("model_leds", leds, exp_l);
        check("model_frame_done", frame_done, exp_fd);
        if (exp_fd) check("model_frame_ch", frame_ch, c);
    endtask

    task automatic cycle3(input bit v, input int c, input int d, input int ds);
        v3 = v; ch3 = c[1:0]; data3 = d[11:0]; disp3 = ds[1:0]; mode3 = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct { bit v; int ch; int data; int ds; int md; int leds; bit fd; } vec_t;
    vec_t tbl[$];

    task automatic add(input bit v, input int d, input int md, input int l, input bit fd);
        vec_t r;
        r.v = v; r.ch = 0; r.data = d; r.ds = 0; r.md = md; r.leds = l; r.fd = fd;
        tbl.push_back(r);
    endtask

    // A full ch0 window of value d: leds stays at l_during, pulse on the 4th
    // sample, then one idle cycle showing l_after.
    task automatic add_win(input int d, input int md, input int l_during, input int l_after);
        for (int k = 0; k < WIN; k++) add(1'b1, d, md, l_during, (k == WIN - 1));
        add(1'b0, 0, md, l_after, 1'b0);
    endtask

    bit seen0, seen1;
    int rc, rd, rds, rmd;
    bit rv;

    initial begin
        model_reset();
        // Linear bar: 2048,3048,2048,2048 -> level 1000 -> 0x0F
        add(1'b1, 2048, 0, 'h00, 1'b0);
        add(1'b1, 3048, 0, 'h00, 1'b0);
        add(1'b1, 2048, 0, 'h00, 1'b0);
        add(1'b1, 2048, 0, 'h00, 1'b1);
        add(1'b0, 0,    0, 'h0F, 1'b0);
        // Negative full scale and zero magnitude
        add_win(0,    0, 'h0F, 'hFF);
        add_win(2047, 0, 'hFF, 'h00);
        // Peak hold then decay (mode 1)
        add_win(0,    1, 'h80, 'hFF);
        add_win(2048, 1, 'hFF, 'h80);
        add_win(2048, 1, 'h80, 'h80);
        add_win(2048, 1, 'h80, 'h20);

        #2;
        check("reset_leds", leds, 8'h00);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_frame_ch", frame_ch, 1'b0);
        check("reset_leds3", leds3, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].ch, tbl[i].data, tbl[i].ds, tbl[i].md);
            check($sformatf("tbl%0d_leds", i), leds, tbl[i].leds);
            check($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].fd);
        end

        // Interleave ch1 full scale with ch0 midpoint
        seen0 = 1'b0; seen1 = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            cycle(1'b1, 1, 4095, 0, 0);
            if (frame_done && frame_ch == 1'b1) seen1 = 1'b1;
            cycle(1'b1, 0, 2048, 0, 0);
            if (frame_done && frame_ch == 1'b0) seen0 = 1'b1;
        end
        check("interleave_seen_ch0", seen0, 1'b1);
        check("interleave_seen_ch1", seen1, 1'b1);
        cycle(1'b0, 0, 0, 0, 0);
        check("sel_ch0_leds", leds, 8'h00);
        cycle(1'b0, 0, 0, 1, 0);
        check("sel_ch1_leds", leds, 8'hFF);
        cycle(1'b0, 0, 0, 0, 0);
        check("sel_back_ch0_leds", leds, 8'h00);

        // Asynchronous reset mid-stream while a pulse is high
        cycle(1'b0, 0, 0, 1, 0);
        cycle(1'b1, 0, 100, 1, 0);
        cycle(1'b1, 0, 100, 1, 0);
        for (int k = 0; k < WIN; k++) cycle(1'b1, 1, 4095, 1, 0);
        check("pre_reset_frame_done", frame_done, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_leds", leds, 8'h00);
        check("async_reset_frame_done", frame_done, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            cycle(1'b1, 0, 4095, 0, 0);
            check($sformatf("post_reset_fd%0d", k), frame_done, (k == WIN - 1));
        end
        check("post_reset_frame_ch", frame_ch, 1'b0);

        // Randomised traffic against the model
        rds = 0; rmd = 0;
        for (int n = 0; n < 1500; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rc = $urandom_range(0, CH - 1);
            case ($urandom_range(0, 3))
                0: rd = $urandom_range(0, 200);
                1: rd = $urandom_range(3900, 4095);
                default: rd = $urandom_range(0, 4095);
            endcase
            if ($urandom_range(0, 39) == 0) rds = $urandom_range(0, CH - 1);
            if ($urandom_range(0, 29) == 0) rmd = $urandom_range(0, 1);
            cycle(rv, rc, rd, rds, rmd);
        end
        sample_valid = 1'b0;

        // Three-channel instance: invalid tag 3 and invalid display select
        cycle3(1'b1, 2, 4095, 2);  check("inv_fd_a", fd3, 1'b0);
        cycle3(1'b1, 3, 0,    2);  check("inv_fd_b", fd3, 1'b0);
        cycle3(1'b1, 2, 4095, 2);  check("inv_fd_c", fd3, 1'b0);
        cycle3(1'b1, 3, 0,    2);  check("inv_fd_d", fd3, 1'b0);
        cycle3(1'b1, 3, 0,    2);  check("inv_fd_e", fd3, 1'b0);
        cycle3(1'b1, 2, 4095, 2);  check("inv_fd_f", fd3, 1'b0);
        cycle3(1'b1, 3, 4095, 2);  check("inv_fd_g", fd3, 1'b0);
        cycle3(1'b1, 2, 4095, 2);  check("inv_fd_h", fd3, 1'b1);
        check("inv_frame_ch", fch3, 2'd2);
        cycle3(1'b0, 0, 0, 2);     check("inv_fd_after", fd3, 1'b0);
        check("ch2_leds", leds3, 8'hFF);
        cycle3(1'b0, 0, 0, 0);     check("ch0_untouched_leds", leds3, 8'h00);
        cycle3(1'b0, 0, 0, 3);     check("disp_sel3_leds", leds3, 8'h00);
        cycle3(1'b0, 0, 0, 2);     check("disp_back_ch2_leds", leds3, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_vu_meter.md
# multi_vu_meter

Parametrised multi-channel VU meter core that replaces the fixed single-channel rectify/max/LED-driver chain behind the ADC interface. It accepts a tagged sample stream from the ADC front end and tracks a per-channel windowed peak level plus a peak-hold marker with decay. It drives an `LEDS`-wide bar graph for one operator-selected channel, in bar or bar-plus-peak-dot mode.

## Interface
- `CHANNELS`, 2: number of ADC channels tracked (1–8).
- `DATA_W`, 12: ADC sample width, offset-binary, midpoint `2^(DATA_W-1)`.
- `LEDS`, 8: bar-graph length (1–16).
- `WINDOW`, 512: accepted samples per channel per level update (≥1).
- `HOLD`, 16: windows the peak marker is held before decay starts.
- `DECAY_SH`, 3: decay shift; the peak drops by `peak>>DECAY_SH` per window, minimum 1.
- `CH_W` (local): `max(1, $clog2(CHANNELS))`.

Ports:
- `clk`, in, 1: single clock. All logic is in this domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `sample_valid`, in, 1: the sample on `sample_data`/`sample_ch` is accepted on this edge.
- `sample_ch`, in, CH_W: channel tag of the sample.
- `sample_data`, in, DATA_W: raw ADC code.
- `disp_sel`, in, CH_W: channel shown on `leds`.
- `mode`, in, 1: 0 = bar, 1 = bar plus peak dot.
- `leds`, out, LEDS: registered bar pattern; bit 0 is the lowest LED.
- `frame_done`, out, 1: one-cycle pulse when any channel completes a window.
- `frame_ch`, out, CH_W: channel that completed; valid while `frame_done` is high.

## Operation
- Rectify (full-wave), producing `mag`, DATA_W-1 bits:
  - `d >= mid`: `mag = d - mid`.
  - `d < mid`: `mag = mid - 1 - d`.
  - Range is 0..2^(DATA_W-1)-1, with no overflow.
- Per-channel state: `run_max`, `level`, `peak` (each DATA_W-1 bits), `win_cnt` (0..WINDOW-1), `hold_cnt` (0..HOLD).
- On each accepted sample for channel c, let `new = max(run_max[c], mag)`:
  - If `win_cnt[c] != WINDOW-1`: `run_max[c] <= new`, `win_cnt[c]++`.
  - Else (window end):
    - `level[c] <= new`, `run_max[c] <= 0`, `win_cnt[c] <= 0`.
    - `frame_done` and `frame_ch` are asserted next cycle.
    - The peak is updated as below.
- Peak update at window end, first matching rule wins:
  - `new >= peak`: `peak <= new`, `hold_cnt <= HOLD`.
  - `hold_cnt != 0`: `hold_cnt--`, peak unchanged.
  - Otherwise decay: `peak <= max(new, peak - max(1, peak>>DECAY_SH))`, floored at 0.
- Quantise: `count(x) = (x * (LEDS+1)) >> (DATA_W-1)`. Full scale gives exactly `LEDS`; the product needs no saturation.
- Display for channel s = `disp_sel`:
  - `bar[i] = (i < count(level[s]))`.
  - mode 0: `leds = bar`.
  - mode 1: `leds = bar | dot`, where `dot` sets bit `count(peak[s])-1` when `count(peak[s]) > 0`.
- Boundary conditions:
  - Samples with `sample_ch >= CHANNELS` are ignored: no state change, no `frame_done`.
  - `disp_sel >= CHANNELS` forces `leds = 0`.
  - `WINDOW = 1`: every accepted sample is a window end.
  - `win_cnt` wraps to 0 only at window end; there is no other wrap.
  - Channels are fully independent. Samples of one channel never advance another's window.
  - At most one sample is accepted per cycle, so window-end events never collide.
  - Reset mid-window discards partial windows. After release, every channel needs a full `WINDOW` samples before its first `frame_done`.

## Timing
- Reset values:
  - `leds = 0`, `frame_done = 0`, `frame_ch = 0`.
  - All `run_max`, `level`, `peak`, `win_cnt`, `hold_cnt` = 0.
- An accepted sample at edge T updates `run_max`/`level`/`peak`/`hold_cnt` at T.
  - `frame_done` is high for the single cycle after T.
  - `leds` reflects the new `level`/`peak` at edge T+1.
- Changes on `disp_sel` or `mode` appear on `leds` one edge later.
- Back-to-back `sample_valid` every cycle is sustained with no stall; there is no ready signal.
- `leds` is glitch-free: a direct flop output.

## Test plan
All scenarios use `CHANNELS=2, DATA_W=12, LEDS=8, WINDOW=4, HOLD=2, DECAY_SH=2` unless noted.

- **Reset:** assert `rst` asynchronously mid-stream → `leds = 0x00` and `frame_done = 0` immediately. After release, 3 ch0 samples give no pulse; the 4th gives `frame_done = 1`, `frame_ch = 0`.
- **Linear bar:** ch0 samples 2048, 3048, 2048, 2048 with `disp_sel = 0`, `mode = 0` → level 1000, count 4, `leds = 0x0F` one cycle after window end.
- **Negative full scale:** ch0 sample 0 ×4 → mag 2047 → `leds = 0xFF`. Sample 2047 ×4 → mag 0 → `leds = 0x00`.
- **Peak hold and decay:**
  - Window of 0s sets peak 2047.
  - Three windows of 2048s follow, with `mode = 1`.
  - `leds = 0x80` for windows 2–3 (hold counts 2→1→0).
  - After window 4 the peak is 1536 and `leds = 0x20`.
- **Interleave and select:**
  - ch1 data 4095 interleaved with ch0 data 2048 → ch0 shows `0x00` and ch1 shows `0xFF`.
  - Both `frame_ch` values are reported.
  - Toggling `disp_sel` switches `leds` within 1 cycle.
- **Invalid tags:** `CHANNELS = 3`.
  - `sample_ch = 3` is ignored: no `frame_done`, counts unchanged.
  - `disp_sel = 3` → `leds = 0x00`.
